// File: rtl/rr_mux_stage_pkg.sv
// Shared constants and helpers for the round-robin multiplexer stage.
// Default geometry plus the index-width function used for SEL_W.
package rr_mux_stage_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_NUM_IN = 4;

    // Smallest r with 2**r >= n, so an index of r bits addresses n channels.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < n) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_mux_stage_arbiter.sv
// Grant logic: pointer-rotated priority search with a forced-select override.
// Purely combinational; produces a one-hot grant and its binary index.
module rr_arbiter
    import rr_mux_stage_pkg::*;
#(
    parameter int NUM_IN = DEF_NUM_IN,
    parameter int SEL_W  = clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    input  logic              force_en,
    input  logic [SEL_W-1:0]  force_sel,
    output logic [NUM_IN-1:0] grant,
    output logic [SEL_W-1:0]  grant_idx,
    output logic              grant_vld
);

    logic             found_s;
    logic [SEL_W-1:0] idx_s;
    logic [SEL_W:0]   sum_s;
    logic [SEL_W-1:0] cand_s;

    // Search for the granted channel; forced mode never consults the pointer.
    always_comb begin
        found_s = 1'b0;
        idx_s   = '0;
        sum_s   = '0;
        cand_s  = '0;
        if (force_en) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (!found_s && (force_sel == SEL_W'(i)) && req[i]) begin
                    found_s = 1'b1;
                    idx_s   = SEL_W'(i);
                end else begin
                    found_s = found_s;
                end
            end
        end else begin
            for (int k = 0; k < NUM_IN; k++) begin
                sum_s = {1'b0, ptr} + (SEL_W+1)'(k);
                if (sum_s >= (SEL_W+1)'(NUM_IN)) begin
                    sum_s = sum_s - (SEL_W+1)'(NUM_IN);
                end else begin
                    sum_s = sum_s;
                end
                cand_s = sum_s[SEL_W-1:0];
                if (!found_s && req[cand_s]) begin
                    found_s = 1'b1;
                    idx_s   = cand_s;
                end else begin
                    found_s = found_s;
                end
            end
        end
    end

    // Expand the winning index into the one-hot grant vector.
    always_comb begin
        grant = '0;
        if (found_s) begin
            grant[idx_s] = 1'b1;
        end else begin
            grant = '0;
        end
    end

    assign grant_idx = idx_s;
    assign grant_vld = found_s;

endmodule

// File: rtl/rr_mux_stage.sv
// Round-robin (or forced-select) N:1 multiplexer feeding a one-word
// registered output stage with valid/ready handshaking on both sides.
module rr_mux_stage
    import rr_mux_stage_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int NUM_IN = DEF_NUM_IN,
    parameter int SEL_W  = clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic                    force_en,
    input  logic [SEL_W-1:0]        force_sel,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_src,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic [WIDTH-1:0]  out_data_q,  out_data_d;
    logic [SEL_W-1:0]  out_src_q,   out_src_d;
    logic              out_valid_q, out_valid_d;
    logic [SEL_W-1:0]  ptr_q,       ptr_d;

    logic [NUM_IN-1:0] grant_s;
    logic [SEL_W-1:0]  grant_idx_s;
    logic              grant_vld_s;
    logic              accept_s;
    logic              xfer_s;
    logic [WIDTH-1:0]  sel_data_s;

    rr_arbiter #(
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_arb (
        .req       (in_valid),
        .ptr       (ptr_q),
        .force_en  (force_en),
        .force_sel (force_sel),
        .grant     (grant_s),
        .grant_idx (grant_idx_s),
        .grant_vld (grant_vld_s)
    );

    // rst gating keeps in_ready low during reset even though out_valid_q is 0 then.
    assign accept_s = (~out_valid_q | out_ready) & ~rst;
    assign xfer_s   = accept_s & grant_vld_s;
    assign in_ready = xfer_s ? grant_s : '0;

    // Data mux indexed by the grant; only the granted lane reaches the register.
    always_comb begin
        sel_data_s = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant_idx_s == SEL_W'(i)) begin
                sel_data_s = in_data[i*WIDTH +: WIDTH];
            end else begin
                sel_data_s = sel_data_s;
            end
        end
    end

    // Next-state for the output register and the round-robin pointer.
    always_comb begin
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (xfer_s) begin
            out_data_d  = sel_data_s;
            out_src_d   = grant_idx_s;
            out_valid_d = 1'b1;
            if (!force_en) begin
                ptr_d = (grant_idx_s == SEL_W'(NUM_IN-1)) ? '0 : grant_idx_s + SEL_W'(1);
            end else begin
                ptr_d = ptr_q;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_mux_stage.sv
// Self-checking bench for rr_mux_stage (WIDTH=8, NUM_IN=4): vector table
// with a data scoreboard, plus hand-written reset sequences.
module tb_rr_mux_stage;

    logic        clk;
    logic        rst;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic        force_en;
    logic [1:0]  force_sel;
    logic [7:0]  out_data;
    logic [1:0]  out_src;
    logic        out_valid;
    logic        out_ready;

    rr_mux_stage #(.WIDTH(8), .NUM_IN(4), .SEL_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .force_en  (force_en),
        .force_sel (force_sel),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] vld;
        logic       fen;
        logic [1:0] fsel;
        logic       ordy;
        logic [3:0] exp_rdy;
        logic       exp_ov;
    } vec_t;

    localparam int NVEC = 20;
    vec_t       tbl [NVEC];
    logic [9:0] sb_q [$];
    logic [9:0] exp_hold;
    logic [7:0] chd  [4];
    logic [7:0] base [4];
    int         n_chk;
    int         n_fail;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] vld, input logic fen, input logic [1:0] fsel,
                                input logic ordy, input logic [3:0] rdy, input logic ov);
        vec_t v;
        v.vld = vld; v.fen = fen; v.fsel = fsel; v.ordy = ordy; v.exp_rdy = rdy; v.exp_ov = ov;
        return v;
    endfunction

    function automatic logic [1:0] oh2idx(input logic [3:0] oh);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) r = 2'(i);
        end
        return r;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] gi;
        n_chk = 0; n_fail = 0;
        base[0] = 8'h10; base[1] = 8'h21; base[2] = 8'h32; base[3] = 8'h43;
        // ptr before each row: 0,1,2,3,0 | 1,1,1,1 | 2,2 | 3,1 | 3,3,3,3 | 0,1,1
        tbl[0]  = mk(4'b1111, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b1);
        tbl[1]  = mk(4'b1111, 1'b0, 2'd0, 1'b1, 4'b0010, 1'b1);
        tbl[2]  = mk(4'b1111, 1'b0, 2'd0, 1'b1, 4'b0100, 1'b1);
        tbl[3]  = mk(4'b1111, 1'b0, 2'd0, 1'b1, 4'b1000, 1'b1);
        tbl[4]  = mk(4'b1111, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b1);
        tbl[5]  = mk(4'b1111, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1);
        tbl[6]  = mk(4'b1111, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1);
        tbl[7]  = mk(4'b1111, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1);
        tbl[8]  = mk(4'b1111, 1'b0, 2'd0, 1'b1, 4'b0010, 1'b1);
        tbl[9]  = mk(4'b0000, 1'b0, 2'd0, 1'b1, 4'b0000, 1'b0);
        tbl[10] = mk(4'b0100, 1'b0, 2'd0, 1'b1, 4'b0100, 1'b1);
        tbl[11] = mk(4'b0101, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b1);
        tbl[12] = mk(4'b0101, 1'b0, 2'd0, 1'b1, 4'b0100, 1'b1);
        tbl[13] = mk(4'b0100, 1'b1, 2'd2, 1'b1, 4'b0100, 1'b1);
        tbl[14] = mk(4'b1011, 1'b1, 2'd2, 1'b1, 4'b0000, 1'b0);
        tbl[15] = mk(4'b1011, 1'b1, 2'd3, 1'b1, 4'b1000, 1'b1);
        tbl[16] = mk(4'b1111, 1'b0, 2'd0, 1'b1, 4'b1000, 1'b1);
        tbl[17] = mk(4'b1111, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b1);
        tbl[18] = mk(4'b0111, 1'b1, 2'd3, 1'b0, 4'b0000, 1'b1);
        tbl[19] = mk(4'b0000, 1'b0, 2'd0, 1'b1, 4'b0000, 1'b0);

        // Reset with every channel requesting.
        rst = 1'b1; in_valid = 4'b1111; in_data = 32'h43322110;
        force_en = 1'b0; force_sel = 2'd0; out_ready = 1'b1;
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_src",   32'(out_src),   32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        in_valid = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        exp_hold = 10'd0;
        @(posedge clk);
        #1;

        for (int r = 0; r < NVEC; r++) begin
            for (int c = 0; c < 4; c++) begin
                chd[c] = (r < 5) ? base[c] : 8'($urandom_range(0, 255));
            end
            in_valid  = tbl[r].vld;
            force_en  = tbl[r].fen;
            force_sel = tbl[r].fsel;
            out_ready = tbl[r].ordy;
            in_data   = {chd[3], chd[2], chd[1], chd[0]};
            #3;
            chk($sformatf("row%0d_in_ready", r), 32'(in_ready), 32'(tbl[r].exp_rdy));
            if (tbl[r].exp_rdy != 4'b0000) begin
                gi = oh2idx(tbl[r].exp_rdy);
                sb_q.push_back({gi, chd[gi]});
            end
            @(posedge clk);
            #1;
            if (tbl[r].exp_rdy != 4'b0000) begin
                if (sb_q.size() > 0) exp_hold = sb_q.pop_front();
            end
            chk($sformatf("row%0d_out_valid", r), 32'(out_valid), 32'(tbl[r].exp_ov));
            chk($sformatf("row%0d_out_data", r),  32'(out_data),  32'(exp_hold[7:0]));
            chk($sformatf("row%0d_out_src", r),   32'(out_src),   32'(exp_hold[9:8]));
        end

        // Load one word (ptr is 1 here, so channel 1), then reset mid-cycle while it is held.
        in_valid = 4'b1111; force_en = 1'b0; out_ready = 1'b1;
        in_data  = {8'h44, 8'h33, 8'hA7, 8'h11};
        @(posedge clk);
        #1;
        chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
        chk("pre_rst_out_data",  32'(out_data),  32'hA7);
        out_ready = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_data",  32'(out_data),  32'd0);
        chk("mid_rst_in_ready",  32'(in_ready),  32'd0);
        in_valid = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_idle_valid", 32'(out_valid), 32'd0);
        in_valid = 4'b1111; out_ready = 1'b1;
        in_data  = {8'h44, 8'h33, 8'h22, 8'h5A};
        #3;
        chk("post_rst_in_ready", 32'(in_ready), 32'b0001);
        @(posedge clk);
        #1;
        chk("post_rst_out_valid", 32'(out_valid), 32'd1);
        chk("post_rst_out_data",  32'(out_data),  32'h5A);
        chk("post_rst_out_src",   32'(out_src),   32'd0);
        in_valid = 4'b0000;
        @(posedge clk);
        #1;
        chk("post_rst_drain", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_mux_stage.md
RR_MUX_STAGE -- requirements
Module: rr_mux_stage

Interface
REQ-001 Parameter WIDTH, default 8, data bits per channel.
REQ-002 Parameter NUM_IN, default 4, input channel count; legal range 2..16.
REQ-003 Parameter SEL_W, default 2, index width; SHALL equal clog2(NUM_IN).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_data  input  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  input  NUM_IN  per-channel request.
REQ-008 in_ready  output  NUM_IN  per-channel accept, combinational, at most one bit high.
REQ-009 force_en  input  1  1 = forced-select mode; 0 = round-robin mode.
REQ-010 force_sel  input  SEL_W  channel index used in forced mode.
REQ-011 out_data  output  WIDTH  registered selected data.
REQ-012 out_src  output  SEL_W  registered index of the channel that supplied out_data.
REQ-013 out_valid  output  1  registered output holds a word.
REQ-014 out_ready  input  1  downstream accept.

Function
REQ-015 accept = !out_valid | out_ready; a transfer from channel g occurs when accept & in_valid[g] & (g is granted).
REQ-016 Round-robin mode: grant the first channel with in_valid high, searching ptr, ptr+1, ..., NUM_IN-1, then 0 .. ptr-1 (wrap-around).
REQ-017 Forced mode: grant force_sel only if force_sel < NUM_IN and in_valid[force_sel]; otherwise no grant.
REQ-018 in_ready[g] = accept & grant[g]; in_ready SHALL be all-zero when accept is 0 or no channel is granted.
REQ-019 On a transfer: out_data <= channel g data, out_src <= g, out_valid <= 1 on the next edge; latency exactly 1 cycle.
REQ-020 When out_valid & out_ready and no transfer: out_valid <= 0; out_data and out_src hold.
REQ-021 Simultaneous drain and load (out_valid & out_ready & transfer): the new word replaces the old in one cycle; sustained throughput 1 word/cycle.
REQ-022 When out_valid & !out_ready: out_data, out_src, out_valid hold; no input is accepted.
REQ-023 Pointer ptr (SEL_W bits): after a round-robin transfer from g, ptr <= g+1, or 0 if g = NUM_IN-1; otherwise ptr holds.
REQ-024 Forced-mode transfers SHALL NOT change ptr.
REQ-025 Mode change (force_en toggling) takes effect in the same cycle; no transfer is lost or duplicated.
REQ-026 Input data of non-granted channels SHALL NOT affect any output or state.

Reset
REQ-027 While rst=1: out_valid=0, out_data=0, out_src=0, ptr=0, immediately (asynchronous), independent of clk.
REQ-028 Reset asserted mid-transfer discards the held word; first grant after release starts search at channel 0.
REQ-029 in_ready SHALL be all-zero while rst=1.

Structure
REQ-030 Shared package/include holds default WIDTH and NUM_IN constants and the clog2 function used for SEL_W.
REQ-031 Grant logic (pointer-rotated priority search plus forced override) SHALL be a sub-module rr_arbiter with inputs req, ptr, force_en, force_sel and one-hot output grant plus binary index.
REQ-032 Data selection is a WIDTH-wide NUM_IN:1 mux driven by the grant index; no latches, single clock domain.

Verification (WIDTH=8, NUM_IN=4)
REQ-033 Reset: rst=1 with in_valid=4'b1111 -> out_valid=0, out_data=0, in_ready=0; after release the first grant is channel 0.
REQ-034 All valid, out_ready=1, data ch0..3 = 0x10,0x21,0x32,0x43 -> out_data sequence 0x10,0x21,0x32,0x43,0x10 on consecutive cycles, out_src 0,1,2,3,0.
REQ-035 Backpressure: out_valid=1, out_ready=0 for 3 cycles -> out_data stable, in_ready=0; out_ready=1 -> next word loads in the same cycle the old drains.
REQ-036 Wrap-around: ptr=3, in_valid=4'b0101 -> grant channel 0 (not 2); ptr becomes 1.
REQ-037 Forced mode: force_en=1, force_sel=2, in_valid=4'b0100 -> ch2 accepted, ptr unchanged; force_sel=2 with in_valid=4'b1011 -> no grant, in_ready=0.
REQ-038 Reset mid-stream: assert rst between clock edges while out_valid=1 -> out_valid drops immediately; no word from before reset appears afterwards.
